imm_gen_stage: RTL and testbench

Registered immediate-generation stage for the decode pipeline. It replaces the purely combinational sign extender with a parametrised unit that supports RV32 and RV64 (`XLEN`) and either decodes the immediate format from the opcode or takes an externally driven `imm_src`. It adds the CSR zimm format and buffers results in a 2-entry skid buffer with valid/ready handshaking and flush. It sits between instruction fetch/decode and the ALU-operand mux.

---
 rtl/imm_pkg.sv | 43 ++++
 rtl/imm_gen_stage_decode.sv | 34 +++
 rtl/imm_gen_stage.sv | 143 ++++++++++++++
 tb/tb_imm_gen_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate-generation stage.
//   imm_fmt_t  : 3-bit immediate format encoding
//   imm_meta_t : per-entry format/no-immediate payload carried through the buffer
//   OP_*       : RISC-V major opcodes used by auto-decode
//   xlen_legal : elaboration-time check on the result width
package imm_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned FMT_W   = 3;
  localparam int unsigned OP_W    = 7;

  typedef enum logic [FMT_W-1:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_J    = 3'b011,
    IMM_Z    = 3'b100,
    IMM_NONE = 3'b110,
    IMM_U    = 3'b111
  } imm_fmt_t;

  typedef struct packed {
    imm_fmt_t fmt;
    logic     no_imm;
  } imm_meta_t;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_IMM_32 = 7'b0011011;
  localparam logic [OP_W-1:0] OP_SYSTEM = 7'b1110011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;

  // Only RV32 and RV64 result widths are supported.
  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_gen_stage_decode.sv
// Combinational immediate extractor.
//   instr  : instruction bits [31:7] (the opcode field is not needed here)
//   fmt    : format to apply
//   imm    : XLEN-wide extended immediate (0 for formats without one)
//   no_imm : the format carries no immediate
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_fmt_t        fmt,
  output logic [XLEN-1:0] imm,
  output logic            no_imm
);

  // Signed casts sign-extend to XLEN; Z is the only zero-extended format.
  always_comb begin
    imm    = '0;
    no_imm = 1'b0;
    case (fmt)
      IMM_I: imm = XLEN'($signed(instr[31:20]));
      IMM_S: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B: imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                  instr[11:8], 1'b0}));
      IMM_J: imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                  instr[30:21], 1'b0}));
      IMM_Z: imm = XLEN'(instr[19:15]);
      IMM_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
      default: no_imm = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a 2-entry skid buffer.
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : input handshake (instr, imm_src)
//   instr              : raw 32-bit instruction
//   imm_src            : external format select, used when AUTO_DECODE = 0
//   flush              : drop all buffered entries and the current input
//   out_valid/out_ready: output handshake (imm_op, imm_fmt, no_imm)
//   imm_op             : XLEN-wide extended immediate
//   imm_fmt            : format that was applied
//   no_imm             : instruction has no immediate, imm_op = 0
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          AUTO_DECODE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_op,
  output logic [2:0]      imm_fmt,
  output logic            no_imm
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  imm_fmt_t        auto_fmt_c;
  imm_fmt_t        fmt_c;
  logic [XLEN-1:0] dec_imm_c;
  logic            dec_no_imm_c;
  imm_meta_t       dec_meta_c;

  logic            accept_c;
  logic            out_free_c;

  imm_meta_t       out_meta;
  logic            skid_valid;
  logic [XLEN-1:0] skid_imm;
  imm_meta_t       skid_meta;

  logic            out_valid_d;
  logic [XLEN-1:0] out_imm_d;
  imm_meta_t       out_meta_d;
  logic            skid_valid_d;
  logic [XLEN-1:0] skid_imm_d;
  imm_meta_t       skid_meta_d;

  // Opcode-driven format selection; ADDIW-class opcodes only exist on RV64.
  always_comb begin
    auto_fmt_c = IMM_NONE;
    case (instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR: auto_fmt_c = IMM_I;
      OP_IMM_32:                auto_fmt_c = (XLEN == 64) ? IMM_I : IMM_NONE;
      OP_SYSTEM:                auto_fmt_c = instr[14] ? IMM_Z : IMM_I;
      OP_STORE:                 auto_fmt_c = IMM_S;
      OP_BRANCH:                auto_fmt_c = IMM_B;
      OP_JAL:                   auto_fmt_c = IMM_J;
      OP_LUI, OP_AUIPC:         auto_fmt_c = IMM_U;
      default:                  auto_fmt_c = IMM_NONE;
    endcase
  end

  assign fmt_c = AUTO_DECODE ? auto_fmt_c : imm_fmt_t'(imm_src);

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr  (instr[31:7]),
    .fmt    (fmt_c),
    .imm    (dec_imm_c),
    .no_imm (dec_no_imm_c)
  );

  assign dec_meta_c = '{fmt: fmt_c, no_imm: dec_no_imm_c};

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready   = !skid_valid;
  assign accept_c   = in_valid && !skid_valid;
  assign out_free_c = !out_valid || out_ready;

  // Buffer next-state: skid entry has priority into the output slot to keep FIFO order.
  always_comb begin
    out_valid_d  = out_valid;
    out_imm_d    = imm_op;
    out_meta_d   = out_meta;
    skid_valid_d = skid_valid;
    skid_imm_d   = skid_imm;
    skid_meta_d  = skid_meta;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free_c) begin
      if (skid_valid) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm;
        out_meta_d   = skid_meta;
        skid_valid_d = 1'b0;
      end else if (accept_c) begin
        out_valid_d = 1'b1;
        out_imm_d   = dec_imm_c;
        out_meta_d  = dec_meta_c;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept_c) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm_c;
      skid_meta_d  = dec_meta_c;
    end
  end

  // Entry registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      imm_op     <= '0;
      out_meta   <= '{fmt: IMM_I, no_imm: 1'b0};
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_meta  <= '{fmt: IMM_I, no_imm: 1'b0};
    end else begin
      out_valid  <= out_valid_d;
      imm_op     <= out_imm_d;
      out_meta   <= out_meta_d;
      skid_valid <= skid_valid_d;
      skid_imm   <= skid_imm_d;
      skid_meta  <= skid_meta_d;
    end
  end

  assign imm_fmt = out_meta.fmt;
  assign no_imm  = out_meta.no_imm;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed self-checking bench for imm_gen_stage: RV32 auto-decode, RV64
// auto-decode and RV32 external-select instances share one input stream.
module tb_imm_gen_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic        flush;
  logic        out_ready;

  logic        d32_in_ready, d32_out_valid, d32_no_imm;
  logic [31:0] d32_imm;
  logic [2:0]  d32_fmt;
  logic        d64_in_ready, d64_out_valid, d64_no_imm;
  logic [63:0] d64_imm;
  logic [2:0]  d64_fmt;
  logic        dx_in_ready, dx_out_valid, dx_no_imm;
  logic [31:0] dx_imm;
  logic [2:0]  dx_fmt;

  int checks = 0;
  int passed = 0;

  imm_gen_stage #(.XLEN(32), .AUTO_DECODE(1'b1)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d32_in_ready),
    .instr(instr), .imm_src(imm_src), .flush(flush),
    .out_valid(d32_out_valid), .out_ready(out_ready),
    .imm_op(d32_imm), .imm_fmt(d32_fmt), .no_imm(d32_no_imm)
  );

  imm_gen_stage #(.XLEN(64), .AUTO_DECODE(1'b1)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d64_in_ready),
    .instr(instr), .imm_src(imm_src), .flush(flush),
    .out_valid(d64_out_valid), .out_ready(out_ready),
    .imm_op(d64_imm), .imm_fmt(d64_fmt), .no_imm(d64_no_imm)
  );

  imm_gen_stage #(.XLEN(32), .AUTO_DECODE(1'b0)) dutx (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dx_in_ready),
    .instr(instr), .imm_src(imm_src), .flush(flush),
    .out_valid(dx_out_valid), .out_ready(out_ready),
    .imm_op(dx_imm), .imm_fmt(dx_fmt), .no_imm(dx_no_imm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src);
    in_valid = v;
    instr    = ins;
    imm_src  = src;
  endtask

  // 32-bit instance output triple in one call.
  task automatic chk32(input string tag, input logic [31:0] imm, input logic [2:0] fmt,
                       input logic nimm);
    chk({tag, "_valid"}, 64'(d32_out_valid), 64'd1);
    chk({tag, "_imm"},   64'(d32_imm), 64'(imm));
    chk({tag, "_fmt"},   64'(d32_fmt), 64'(fmt));
    chk({tag, "_noimm"}, 64'(d32_no_imm), 64'(nimm));
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 3'b000);

    #2;
    chk("rst_valid", 64'(d32_out_valid), 64'd0);
    chk("rst_imm",   64'(d32_imm), 64'd0);
    chk("rst_fmt",   64'(d32_fmt), 64'd0);
    chk("rst_noimm", 64'(d32_no_imm), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(d32_in_ready), 64'd1);

    // Streaming with out_ready = 1: one result per cycle, latency 1.
    drive(1'b1, 32'hFFC12083, 3'b001);  // lw x1,-4(x2); ext instance forced to S
    step();
    chk32("lw", 32'hFFFFFFFC, 3'b000, 1'b0);
    chk("lw64_imm", d64_imm, 64'hFFFFFFFFFFFFFFFC);
    chk("ext_s_imm", 64'(dx_imm), 64'hFFFFFFE1);
    chk("ext_s_fmt", 64'(dx_fmt), 64'd1);
    drive(1'b1, 32'hFE112E23, 3'b000);  // sw
    step();
    chk32("sw", 32'hFFFFFFFC, 3'b001, 1'b0);
    drive(1'b1, 32'hFE000CE3, 3'b000);  // beq -8
    step();
    chk32("beq", 32'hFFFFFFF8, 3'b010, 1'b0);
    drive(1'b1, 32'h008000EF, 3'b000);  // jal +8
    step();
    chk32("jal", 32'h00000008, 3'b011, 1'b0);
    drive(1'b1, 32'h300FD073, 3'b000);  // csrrwi, zimm 31
    step();
    chk32("csrrwi", 32'h0000001F, 3'b100, 1'b0);
    drive(1'b1, 32'h00001017, 3'b000);  // auipc
    step();
    chk32("auipc", 32'h00001000, 3'b111, 1'b0);
    drive(1'b1, 32'h002081B3, 3'b101);  // R-type; ext instance uses 101
    step();
    chk32("rtype", 32'h0, 3'b110, 1'b1);
    chk("ext_101_imm",   64'(dx_imm), 64'd0);
    chk("ext_101_fmt",   64'(dx_fmt), 64'd5);
    chk("ext_101_noimm", 64'(dx_no_imm), 64'd1);
    drive(1'b1, 32'hFFF0809B, 3'b000);  // addiw: RV64 only
    step();
    chk32("addiw32", 32'h0, 3'b110, 1'b1);
    chk("addiw64_imm", d64_imm, 64'hFFFFFFFFFFFFFFFF);
    chk("addiw64_fmt", 64'(d64_fmt), 64'd0);
    drive(1'b1, 32'h123450B7, 3'b000);  // lui positive
    step();
    chk("lui64_pos", d64_imm, 64'h0000000012345000);
    chk("lui64_fmt", 64'(d64_fmt), 64'd7);
    chk("lui32_pos", 64'(d32_imm), 64'h12345000);
    drive(1'b1, 32'h800000B7, 3'b000);  // lui negative
    step();
    chk("lui64_neg", d64_imm, 64'hFFFFFFFF80000000);
    chk("lui32_neg", 64'(d32_imm), 64'h80000000);
    drive(1'b0, 32'h0, 3'b000);
    step();
    chk("idle_valid", 64'(d32_out_valid), 64'd0);

    // Backpressure: three instructions offered, only two taken.
    out_ready = 1'b0;
    drive(1'b1, 32'hFFC12083, 3'b000);  // A: -4
    step();
    chk("bp_a_imm",   64'(d32_imm), 64'hFFFFFFFC);
    chk("bp_a_ready", 64'(d32_in_ready), 64'd1);
    drive(1'b1, 32'h00500093, 3'b000);  // B: 5
    step();
    chk("bp_b_ready", 64'(d32_in_ready), 64'd0);
    chk("bp_hold1",   64'(d32_imm), 64'hFFFFFFFC);
    drive(1'b1, 32'h06400093, 3'b000);  // C: 100
    step();
    chk("bp_c_ready", 64'(d32_in_ready), 64'd0);
    chk("bp_hold2",   64'(d32_imm), 64'hFFFFFFFC);
    chk("bp_hold_v",  64'(d32_out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    chk("bp_out_b",   64'(d32_imm), 64'd5);
    chk("bp_rise",    64'(d32_in_ready), 64'd1);
    step();
    chk("bp_out_c",   64'(d32_imm), 64'd100);
    chk("bp_out_c_v", 64'(d32_out_valid), 64'd1);
    drive(1'b0, 32'h0, 3'b000);
    step();
    chk("bp_drained", 64'(d32_out_valid), 64'd0);

    // Flush with both entries held and an input pending.
    out_ready = 1'b0;
    drive(1'b1, 32'hFFC12083, 3'b000);
    step();
    drive(1'b1, 32'h00500093, 3'b000);
    step();
    chk("fl_full", 64'(d32_in_ready), 64'd0);
    drive(1'b1, 32'h06400093, 3'b000);
    flush = 1'b1;
    step();
    chk("fl_valid", 64'(d32_out_valid), 64'd0);
    chk("fl_ready", 64'(d32_in_ready), 64'd1);
    // Flush while in_ready = 1: the presented entry is dropped.
    drive(1'b1, 32'h00700093, 3'b000);
    step();
    chk("fl_drop_v", 64'(d32_out_valid), 64'd0);
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 3'b000);
    step();
    chk("fl_never_out", 64'(d32_out_valid), 64'd0);

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 3'b000);  // R-type: fmt 110, no_imm 1
    step();
    chk("ar_pre_noimm", 64'(d32_no_imm), 64'd1);
    drive(1'b1, 32'hFE112E23, 3'b000);
    step();
    drive(1'b0, 32'h0, 3'b000);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid",    64'(d32_out_valid), 64'd0);
    chk("ar_imm",      64'(d32_imm), 64'd0);
    chk("ar_fmt",      64'(d32_fmt), 64'd0);
    chk("ar_noimm",    64'(d32_no_imm), 64'd0);
    chk("ar_ready",    64'(d32_in_ready), 64'd1);
    chk("ar64_ready",  64'(d64_in_ready), 64'd1);
    chk("arx_ready",   64'(dx_in_ready), 64'd1);
    chk("ar64_valid",  64'(d64_out_valid), 64'd0);
    chk("arx_valid",   64'(dx_out_valid), 64'd0);
    chk("ar64_noimm",  64'(d64_no_imm), 64'd0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("ar_after", 64'(d32_out_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
